// File: rtl/usb_desc_pkg.sv
// Shared types for the USB descriptor ROM reader.
//   desc_type_e : wValue high byte values for the supported descriptor types
//   rd_state_e  : reader FSM states
//   lut_sel_t   : result of the type/index -> LUT entry mapping
//   lut_index() : maps (type, index) to a LUT entry, or flags it unsupported
package usb_desc_pkg;

  typedef enum logic [7:0] {
    DESC_DEVICE        = 8'd1,
    DESC_CONFIGURATION = 8'd2,
    DESC_STRING        = 8'd3
  } desc_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUT_RD,
    ST_LEN_RD,
    ST_STREAM,
    ST_DONE,
    ST_ERROR
  } rd_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
  } lut_sel_t;

  // LUT order: device, configurations, string zero, strings 1..num_strings.
  // String zero and string k share the formula 1 + num_configs + idx.
  function automatic lut_sel_t lut_index(input logic [7:0] desc_type,
                                         input logic [7:0] desc_idx,
                                         input int         num_configs,
                                         input int         num_strings);
    lut_sel_t sel;
    sel.valid = 1'b0;
    sel.idx   = 8'd0;
    case (desc_type)
      DESC_DEVICE: begin
        sel.valid = 1'b1;
        sel.idx   = 8'd0;
      end
      DESC_CONFIGURATION: begin
        if (int'(desc_idx) < num_configs) begin
          sel.valid = 1'b1;
          sel.idx   = 8'(1 + int'(desc_idx));
        end
      end
      DESC_STRING: begin
        if (num_strings > 0 && int'(desc_idx) <= num_strings) begin
          sel.valid = 1'b1;
          sel.idx   = 8'(1 + num_configs + int'(desc_idx));
        end
      end
      default: sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/usb_desc_prefetch_buf.sv
// Two-entry byte buffer sitting between the synchronous descriptor ROM and
// the EP0 IN packetiser. A read issued in one cycle returns one cycle later
// and is pushed then; slot_free tells the reader whether a read issued now
// is guaranteed a slot when it returns.
//   clk48, rst_n : clock, async active-low reset
//   flush        : drop buffered bytes and the in-flight read
//   issue        : a ROM read is issued this cycle
//   rom_data     : ROM data, valid the cycle after issue
//   out_*        : valid/ready byte stream towards the packetiser
//   slot_free    : a read may be issued this cycle
module usb_desc_prefetch_buf (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       issue,
  input  logic [7:0] rom_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       slot_free
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       rd_pend;
  logic       push;
  logic       pop;

  assign push      = rd_pend;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  // Occupancy next cycle, counting the read already in flight and the byte
  // leaving now; a new read is safe only if that leaves a slot.
  assign slot_free = ({1'b0, count} + {2'b00, rd_pend} - {2'b00, pop}) < 3'd2;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= 8'd0;
      mem[1]  <= 8'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      rd_pend <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (push) begin
        mem[wr_ptr] <= rom_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/usb_desc_rom_reader.sv
// Serves GET_DESCRIPTOR requests from a descriptor ROM image (LUT first, then
// device, configuration and string descriptors). Resolves the descriptor
// start through the LUT, reads its length, and streams
// min(wLength, length) bytes to the EP0 IN packetiser with packet-end,
// transfer-end and zero-length-packet markers.
//   clk48, rst_n           : clock, async active-low reset
//   req*                   : request handshake and wValue/wLength fields
//   abort                  : new SETUP / bus reset, cancels the request
//   romAddr, romData       : synchronous ROM port (data one cycle later)
//   out*, needZlp          : byte stream towards the packetiser
//   reqError               : one-cycle pulse for an unsupported request
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a request, reqReady high
// ST_LUT_RD | reading the LUT entry bytes, LSB first
// ST_LEN_RD | reading bLength, or wTotalLength for configurations
// ST_STREAM | prefetching and handing out descriptor bytes
// ST_DONE   | transfer finished, one cycle before IDLE
// ST_ERROR  | unsupported request, reqError high for one cycle
module usb_desc_rom_reader
  import usb_desc_pkg::*;
#(
  parameter int ROM_SIZE        = 128,
  parameter int ROM_IDX_BYTES   = 1,
  parameter int NUM_CONFIGS     = 1,
  parameter int NUM_STRINGS     = 5,
  parameter int MAX_PACKET_SIZE = 64,
  parameter int ROM_ADDR_WID    = $clog2(ROM_SIZE)
) (
  input  logic                    clk48,
  input  logic                    rst_n,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [7:0]              reqDescType,
  input  logic [7:0]              reqDescIdx,
  input  logic [15:0]             reqLength,
  input  logic                    abort,
  output logic [ROM_ADDR_WID-1:0] romAddr,
  input  logic [7:0]              romData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [7:0]              outData,
  output logic                    outPktEnd,
  output logic                    outLast,
  output logic                    needZlp,
  output logic                    reqError
);

  localparam int IDX_W = 8 * ROM_IDX_BYTES;
  localparam int PKT_W = $clog2(MAX_PACKET_SIZE);

  rd_state_e               state;
  lut_sel_t                sel;
  logic [2:0]              rd_cnt;
  logic [IDX_W-1:0]        idx_acc;
  logic [IDX_W-1:0]        idx_full;
  logic [ROM_ADDR_WID-1:0] desc_start;
  logic [ROM_ADDR_WID-1:0] start_now;
  logic                    is_config;
  logic [7:0]              len_lo;
  logic [15:0]             req_len;
  logic [15:0]             len_now;
  logic [15:0]             rem_now;
  logic [15:0]             remaining;
  logic [15:0]             issued;
  logic [15:0]             accepted;
  logic [PKT_W-1:0]        pkt_cnt;
  logic                    len_done;
  logic                    more;
  logic                    slot_free;
  logic                    issue;
  logic                    pop;
  logic                    is_last;

  assign sel = lut_index(reqDescType, reqDescIdx, NUM_CONFIGS, NUM_STRINGS);

  // The top LUT byte is still on romData in the last LUT_RD cycle.
  always_comb begin
    idx_full                 = idx_acc;
    idx_full[IDX_W-1 -: 8]   = romData;
  end
  assign start_now = ROM_ADDR_WID'(idx_full);

  assign len_done = is_config ? (rd_cnt == 3'd2) : (rd_cnt == 3'd1);
  assign len_now  = is_config ? {romData, len_lo} : {8'h00, romData};
  assign rem_now  = (req_len < len_now) ? req_len : len_now;

  assign more    = (issued != remaining);
  assign issue   = (state == ST_STREAM) && more && slot_free && !abort;
  assign pop     = outValid && outReady && !abort;
  assign is_last = (accepted == remaining - 16'd1);

  assign reqReady  = (state == ST_IDLE);
  assign reqError  = (state == ST_ERROR);
  assign outLast   = outValid && is_last;
  assign outPktEnd = outValid && ((pkt_cnt == PKT_W'(MAX_PACKET_SIZE - 1)) || is_last);
  assign needZlp   = outLast && (remaining[PKT_W-1:0] == '0) && (remaining < req_len);

  usb_desc_prefetch_buf u_buf (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .flush     (abort),
    .issue     (issue),
    .rom_data  (romData),
    .out_ready (outReady),
    .out_valid (outValid),
    .out_data  (outData),
    .slot_free (slot_free)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      romAddr    <= '0;
      rd_cnt     <= 3'd0;
      idx_acc    <= '0;
      desc_start <= '0;
      is_config  <= 1'b0;
      len_lo     <= 8'd0;
      req_len    <= 16'd0;
      remaining  <= 16'd0;
      issued     <= 16'd0;
      accepted   <= 16'd0;
      pkt_cnt    <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          rd_cnt <= 3'd0;
          if (reqValid) begin
            req_len   <= reqLength;
            is_config <= (reqDescType == DESC_CONFIGURATION);
            if (sel.valid) begin
              romAddr <= ROM_ADDR_WID'(int'(sel.idx) * ROM_IDX_BYTES);
              state   <= ST_LUT_RD;
            end else begin
              state   <= ST_ERROR;
            end
          end
        end

        ST_LUT_RD: begin
          rd_cnt <= rd_cnt + 3'd1;
          if (int'(rd_cnt) < ROM_IDX_BYTES - 1) romAddr <= romAddr + 1'b1;
          for (int b = 0; b < ROM_IDX_BYTES; b++) begin
            if (int'(rd_cnt) == b + 1) idx_acc[8*b +: 8] <= romData;
          end
          if (int'(rd_cnt) == ROM_IDX_BYTES) begin
            desc_start <= start_now;
            romAddr    <= is_config ? start_now + ROM_ADDR_WID'(2) : start_now;
            rd_cnt     <= 3'd0;
            state      <= ST_LEN_RD;
          end
        end

        ST_LEN_RD: begin
          rd_cnt <= rd_cnt + 3'd1;
          if (is_config && rd_cnt == 3'd0) romAddr <= romAddr + 1'b1;
          if (rd_cnt == 3'd1) len_lo <= romData;
          if (len_done) begin
            remaining <= rem_now;
            romAddr   <= desc_start;
            issued    <= 16'd0;
            accepted  <= 16'd0;
            pkt_cnt   <= '0;
            state     <= (rem_now == 16'd0) ? ST_DONE : ST_STREAM;
          end
        end

        ST_STREAM: begin
          // Hold the address on the final byte so nothing past the
          // descriptor is ever presented to the ROM.
          if (issue) begin
            issued <= issued + 16'd1;
            if (issued + 16'd1 != remaining) romAddr <= romAddr + 1'b1;
          end
          if (pop) begin
            accepted <= accepted + 16'd1;
            pkt_cnt  <= pkt_cnt + 1'b1;
            if (is_last) state <= ST_DONE;
          end
        end

        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A LUT entry pointing outside the ROM, or a descriptor running past its
  // end, means the ROM image was built for a different size.
  lut_in_range: assert property (@(posedge clk48) disable iff (!rst_n)
    (state == ST_LUT_RD && int'(rd_cnt) == ROM_IDX_BYTES && !abort)
      |-> ({1'b0, idx_full} < (IDX_W + 1)'(ROM_SIZE)));

  desc_no_wrap: assert property (@(posedge clk48) disable iff (!rst_n)
    (state == ST_LEN_RD && len_done && rem_now != 16'd0 && !abort)
      |-> (32'(desc_start) + 32'(rem_now) <= 32'(ROM_SIZE)));

endmodule

// File: tb/tb_usb_desc_rom_reader.sv
module tb_usb_desc_rom_reader;
  import usb_desc_pkg::*;

  localparam int ROM_SIZE = 128;
  localparam int AW       = $clog2(ROM_SIZE);
  localparam int MPS      = 16;

  logic          clk48 = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [7:0]    reqDescType = 8'd0;
  logic [7:0]    reqDescIdx = 8'd0;
  logic [15:0]   reqLength = 16'd0;
  logic          abort = 1'b0;
  logic [AW-1:0] romAddr;
  logic [7:0]    romData = 8'd0;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [7:0]    outData;
  logic          outPktEnd;
  logic          outLast;
  logic          needZlp;
  logic          reqError;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom [ROM_SIZE];

  always #5 clk48 = ~clk48;

  always @(posedge clk48) romData <= rom[romAddr];

  usb_desc_rom_reader #(
    .ROM_SIZE        (ROM_SIZE),
    .ROM_IDX_BYTES   (1),
    .NUM_CONFIGS     (1),
    .NUM_STRINGS     (5),
    .MAX_PACKET_SIZE (MPS)
  ) dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqDescType (reqDescType),
    .reqDescIdx  (reqDescIdx),
    .reqLength   (reqLength),
    .abort       (abort),
    .romAddr     (romAddr),
    .romData     (romData),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outPktEnd   (outPktEnd),
    .outLast     (outLast),
    .needZlp     (needZlp),
    .reqError    (reqError)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ROM image: LUT at 0..7, device@8 (18B), config@26 (32B), string0@58,
  // string1@62, string2@66, string3@70 (34B), string4@104, string5@110 (bLength 0).
  task automatic fill_rom();
    for (int a = 0; a < ROM_SIZE; a++) rom[a] = 8'hEE;
    rom[0] = 8'd8;  rom[1] = 8'd26; rom[2] = 8'd58;  rom[3] = 8'd62;
    rom[4] = 8'd66; rom[5] = 8'd70; rom[6] = 8'd104; rom[7] = 8'd110;
    for (int i = 0; i < 18; i++) rom[8 + i] = 8'(8'h80 + i);
    rom[8] = 8'd18; rom[9] = 8'd1;
    for (int i = 0; i < 32; i++) rom[26 + i] = 8'(8'hA0 + i);
    rom[26] = 8'd9; rom[27] = 8'd2; rom[28] = 8'd32; rom[29] = 8'd0;
    rom[58] = 8'h04; rom[59] = 8'h03; rom[60] = 8'h09; rom[61] = 8'h04;
    rom[62] = 8'h04; rom[63] = 8'h03; rom[64] = 8'h61; rom[65] = 8'h00;
    rom[66] = 8'h04; rom[67] = 8'h03; rom[68] = 8'h62; rom[69] = 8'h00;
    for (int i = 0; i < 34; i++) rom[70 + i] = 8'(8'h40 + i);
    rom[70] = 8'h22; rom[71] = 8'h03;
    rom[104] = 8'h06; rom[105] = 8'h03;
    rom[110] = 8'h00; rom[111] = 8'h03;
  endtask

  task automatic send_req(input logic [7:0] dt, input logic [7:0] di, input logic [15:0] wl);
    @(negedge clk48);
    check("req_ready", reqReady, 1);
    reqDescType = dt;
    reqDescIdx  = di;
    reqLength   = wl;
    reqValid    = 1'b1;
    @(posedge clk48);
    #1;
    reqValid = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] dt, input logic [7:0] di,
                          input logic [15:0] wl, input int exp_n, input int start,
                          input logic exp_zlp, input int ready_pct, input int abort_after);
    int         got;
    int         cyc;
    int         lat;
    logic       aborted;
    logic       extra;
    logic       err;
    logic       prev_stall;
    logic [7:0] prev_data;
    send_req(dt, di, wl);
    got = 0; cyc = 0; aborted = 0; err = 0; prev_stall = 0; prev_data = 8'd0;
    while (got < exp_n && cyc < 1000) begin
      @(negedge clk48);
      cyc++;
      if (reqError) err = 1;
      if (abort_after >= 0 && got == abort_after) begin
        outReady = 1'b1;
        abort    = 1'b1;
        @(negedge clk48);
        abort = 1'b0;
        check({tag, " abort_valid"}, outValid, 0);
        check({tag, " abort_ready"}, reqReady, 1);
        check({tag, " abort_err"}, reqError, 0);
        aborted = 1;
        break;
      end
      if (prev_stall) begin
        check($sformatf("%s hold_valid[%0d]", tag, got), outValid, 1);
        check($sformatf("%s hold_data[%0d]", tag, got), outData, prev_data);
      end
      outReady = ($urandom_range(0, 99) < ready_pct);
      if (outValid && outReady) begin
        check($sformatf("%s data[%0d]", tag, got), outData, rom[start + got]);
        check($sformatf("%s last[%0d]", tag, got), outLast, got == exp_n - 1);
        check($sformatf("%s pktend[%0d]", tag, got), outPktEnd,
              (got % MPS == MPS - 1) || (got == exp_n - 1));
        if (got == exp_n - 1) check({tag, " zlp"}, needZlp, exp_zlp);
        got++;
        prev_stall = 0;
      end else begin
        prev_stall = outValid;
        prev_data  = outData;
      end
    end
    outReady = 1'b1;
    if (!aborted) begin
      check({tag, " nbytes"}, got, exp_n);
      lat = 0; extra = 0;
      while (!reqReady && lat < 30) begin
        @(negedge clk48);
        lat++;
        if (outValid) extra = 1;
        if (reqError) err = 1;
      end
      check({tag, " back_idle"}, reqReady, 1);
      check({tag, " no_extra"}, extra, 0);
      check({tag, " no_err"}, err, 0);
      if (exp_n > 0) check({tag, " ready_lat_le3"}, lat <= 3, 1);
    end
  endtask

  task automatic run_err(input string tag, input logic [7:0] dt, input logic [7:0] di);
    int   pulses;
    logic vseen;
    send_req(dt, di, 16'd255);
    pulses = 0; vseen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk48);
      if (reqError) pulses++;
      if (outValid) vseen = 1;
    end
    check({tag, " err_pulses"}, pulses, 1);
    check({tag, " no_valid"}, vseen, 0);
    check({tag, " ready"}, reqReady, 1);
  endtask

  initial begin
    fill_rom();
    #2;
    check("rst reqReady", reqReady, 1);
    check("rst outValid", outValid, 0);
    check("rst romAddr", romAddr, 0);
    check("rst reqError", reqError, 0);
    check("rst outLast", outLast, 0);
    check("rst outPktEnd", outPktEnd, 0);
    check("rst needZlp", needZlp, 0);
    check("rst outData", outData, 0);
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;

    //        tag            type                 idx    wLength  n   start zlp rdy% abort
    run_xfer("dev64",      DESC_DEVICE,        8'd0, 16'd64,  18, 8,   0, 100, -1);
    run_xfer("dev8",       DESC_DEVICE,        8'd0, 16'd8,   8,  8,   0, 100, -1);
    run_xfer("dev16",      DESC_DEVICE,        8'd0, 16'd16,  16, 8,   0, 100, -1);
    run_xfer("cfg255",     DESC_CONFIGURATION, 8'd0, 16'd255, 32, 26,  1, 100, -1);
    run_xfer("cfg32",      DESC_CONFIGURATION, 8'd0, 16'd32,  32, 26,  0, 100, -1);
    run_xfer("str3",       DESC_STRING,        8'd3, 16'd255, 34, 70,  0, 100, -1);
    check("str3 byte0", rom[70], 8'h22);
    check("str3 byte1", rom[71], 8'h03);
    run_xfer("str0",       DESC_STRING,        8'd0, 16'd255, 4,  58,  0, 100, -1);
    run_xfer("str5_len0",  DESC_STRING,        8'd5, 16'd255, 0,  110, 0, 100, -1);
    run_xfer("dev_wlen0",  DESC_DEVICE,        8'd0, 16'd0,   0,  8,   0, 100, -1);
    run_err("str6", DESC_STRING, 8'd6);
    run_err("type6", 8'd6, 8'd0);
    run_err("cfg1", DESC_CONFIGURATION, 8'd1);
    run_xfer("cfg_rand",   DESC_CONFIGURATION, 8'd0, 16'd255, 32, 26,  1, 50,  -1);
    run_xfer("str3_rand",  DESC_STRING,        8'd3, 16'd255, 34, 70,  0, 50,  -1);
    run_xfer("cfg_abort",  DESC_CONFIGURATION, 8'd0, 16'd255, 32, 26,  1, 100, 5);
    run_xfer("dev_after",  DESC_DEVICE,        8'd0, 16'd64,  18, 8,   0, 100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
